// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg -- shared definitions for the PLL reset controller.
//   pll_state_t : bring-up FSM state encoding
//   DEF_*       : default timing constants used as parameter defaults
//   cnt_width   : width of a counter that must hold the largest timing value
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRDN,
    RESET,
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    FAIL
  } pll_state_t;

  localparam int DEF_NUM_OUT      = 2;
  localparam int DEF_PWD_CYCLES   = 4;
  localparam int DEF_RST_CYCLES   = 8;
  localparam int DEF_LOCK_FILT    = 16;
  localparam int DEF_STAGGER      = 4;
  localparam int DEF_LOCK_TIMEOUT = 1000;
  localparam int DEF_MAX_RETRY    = 3;

  // One extra bit above $clog2 so the largest value itself is representable
  // and the counter never has to wrap.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync -- two-flop synchroniser for the raw PLL lock indication.
//   clk      : controller clock
//   rst_n    : synchronous active-low reset, clears both flops
//   lock_raw : PLL lock, asynchronous to clk
//   lk       : lock, synchronised to clk
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_raw,
  output logic lk
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      lk   <= 1'b0;
    end else begin
      meta <= lock_raw;
      lk   <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl -- PLL power-up / reset sequencer with lock filtering,
// timeout/retry and staggered release of per-clkout resets.
//   clk       : free-running reference clock (same source as PLL clkin1)
//   rst_n     : synchronous active-low reset
//   pll_lock  : raw PLL lock (asynchronous)
//   restart   : single-cycle request to redo the full bring-up
//   pll_pwd   : PLL power-down
//   pll_rst   : PLL reset
//   out_rst_n : per-channel active-low resets, released in order
//   locked    : high in RUN only
//   fail      : high in FAIL only
//   retry_cnt : failed lock attempts in the current bring-up
//   loss_cnt  : (only with PLL_LOSS_CNT_EN) saturating count of lock losses
//               seen in RELEASE/RUN, cleared only by rst_n
// STAGGER is expected to be >= 1 when NUM_OUT > 1.
module pll_rst_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_OUT      = DEF_NUM_OUT,
  parameter int PWD_CYCLES   = DEF_PWD_CYCLES,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_FILT    = DEF_LOCK_FILT,
  parameter int STAGGER      = DEF_STAGGER,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_pwd,
  output logic               pll_rst,
  output logic [NUM_OUT-1:0] out_rst_n,
  output logic               locked,
  output logic               fail,
  output logic [1:0]         retry_cnt
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt
`endif
);

  localparam int CW = cnt_width(PWD_CYCLES, RST_CYCLES, LOCK_FILT, LOCK_TIMEOUT,
                                (NUM_OUT - 1) * STAGGER);

  pll_state_t    state;
  logic [CW-1:0] cnt;       // shared per-state cycle counter
  logic [CW-1:0] tmo;       // lock-wait cycles; kept across FILTER excursions
  logic [CW-1:0] cnt_inc;
  logic          lk;
  logic          go_release;

  pll_lock_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock_raw (pll_lock),
    .lk       (lk)
  );

  assign cnt_inc = cnt + 1'b1;

  // Last required lock-high cycle: cnt holds the lk-high cycles seen so far.
  assign go_release = lk && (((state == WAIT_LOCK) && (LOCK_FILT <= 1)) ||
                             ((state == FILTER) && (cnt_inc == CW'(LOCK_FILT))));

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state     <= PWRDN;
      cnt       <= '0;
      tmo       <= '0;
      retry_cnt <= '0;
      pll_pwd   <= 1'b1;
      pll_rst   <= 1'b1;
      out_rst_n <= '0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else if (go_release) begin
      // Channel 0 comes out of reset on the first RELEASE cycle.
      cnt       <= '0;
      out_rst_n <= NUM_OUT'(1);
      if (NUM_OUT == 1) begin
        state  <= RUN;
        locked <= 1'b1;
      end else begin
        state <= RELEASE;
      end
    end else begin
      unique case (state)
        PWRDN: begin
          if (cnt == CW'(PWD_CYCLES - 1)) begin
            state   <= RESET;
            cnt     <= '0;
            pll_pwd <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESET: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            tmo     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state <= FILTER;
            cnt   <= CW'(1);
          end else if (tmo == CW'(LOCK_TIMEOUT - 1)) begin
            retry_cnt <= retry_cnt + 2'd1;
            pll_rst   <= 1'b1;
            cnt       <= '0;
            if (int'(retry_cnt) + 1 >= MAX_RETRY) begin
              state   <= FAIL;
              pll_pwd <= 1'b1;
              fail    <= 1'b1;
            end else begin
              state <= RESET;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FILTER: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE, RUN: begin
          if (!lk) begin
            // Lock loss: drop every domain reset at once and re-reset the PLL.
            state     <= RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            out_rst_n <= '0;
            locked    <= 1'b0;
          end else if (state == RELEASE) begin
            cnt <= cnt_inc;
            for (int i = 1; i < NUM_OUT; i++) begin
              if (cnt_inc == CW'(i * STAGGER)) out_rst_n[i] <= 1'b1;
            end
            if (cnt_inc == CW'((NUM_OUT - 1) * STAGGER)) begin
              state  <= RUN;
              locked <= 1'b1;
            end
          end
        end
        FAIL: begin
          // Parked with the PLL powered down until restart or rst_n.
        end
        default: begin
          state <= PWRDN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic loss_evt;

  // restart wins over a coincident loss, so it is not counted.
  assign loss_evt = !restart && !lk && ((state == RELEASE) || (state == RUN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  // Lock-loss counter not built.
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// tb_pll_rst_ctrl -- directed self-checking bench for pll_rst_ctrl
// (NUM_OUT=2, default timing). Latencies from a pll_lock edge include the
// two synchroniser cycles.
module tb_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_pwd;
  logic       pll_rst;
  logic [1:0] out_rst_n;
  logic       locked;
  logic       fail;
  logic [1:0] retry_cnt;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  pll_rst_ctrl #(.NUM_OUT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_pwd   (pll_pwd),
    .pll_rst   (pll_rst),
    .out_rst_n (out_rst_n),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then run until WAIT_LOCK is entered (pll_rst falls).
  task automatic bring_to_wait();
    rst_n = 1'b0;
    restart = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0;
    while (pll_rst !== 1'b0 && n < 50) begin tick(); n++; end
    tests++;
    if (n !== 12) begin
      $display("FAIL bring_to_wait: cycles to WAIT_LOCK got %0d want 12", n);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_lock = 1'b1;
    repeat (3) tick();
    tests++;
    if ({pll_pwd, pll_rst, out_rst_n, locked, fail, retry_cnt} !== 8'b11_00_00_00) begin
      $display("FAIL reset_outputs: got pwd=%b rst=%b out=%b lck=%b fail=%b retry=%0d want 1 1 00 0 0 0",
               pll_pwd, pll_rst, out_rst_n, locked, fail, retry_cnt);
      fails++;
    end
    pll_lock = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_bringup();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    while (pll_pwd !== 1'b0 && n < 50) begin tick(); n++; end
    tests++;
    if (n !== 4) begin $display("FAIL pwd_width: got %0d want 4", n); fails++; end
    n = 0;
    while (pll_rst !== 1'b0 && n < 50) begin tick(); n++; end
    tests++;
    if (n !== 8) begin $display("FAIL rst_width: got %0d want 8", n); fails++; end
    repeat (50) tick();
    tests++;
    if ({out_rst_n, locked} !== 3'b000) begin
      $display("FAIL wait_idle: got out=%b lck=%b want 00 0", out_rst_n, locked);
      fails++;
    end
    pll_lock = 1'b1;
    n = 0;
    while (out_rst_n[0] !== 1'b1 && n < 100) begin tick(); n++; end
    tests++;
    if (n !== 18) begin $display("FAIL ch0_release: got %0d want 18", n); fails++; end
    tests++;
    if (out_rst_n !== 2'b01) begin $display("FAIL ch0_only: got %b want 01", out_rst_n); fails++; end
    n = 0;
    while (out_rst_n[1] !== 1'b1 && n < 50) begin tick(); n++; end
    tests++;
    if (n !== 4) begin $display("FAIL ch1_stagger: got %0d want 4", n); fails++; end
    tests++;
    if ({locked, pll_pwd, pll_rst, retry_cnt} !== 5'b1_0_0_00) begin
      $display("FAIL run_state: got lck=%b pwd=%b rst=%b retry=%0d want 1 0 0 0",
               locked, pll_pwd, pll_rst, retry_cnt);
      fails++;
    end
    $display("[TB] test_bringup done");
  endtask

  task automatic test_glitch();
    pll_lock = 1'b0;
    bring_to_wait();
    pll_lock = 1'b1;
    repeat (10) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    // Glitch hits the FSM at filter count 10; a full 16-cycle refilter follows.
    n = 0;
    while (out_rst_n[0] !== 1'b1 && n < 100) begin tick(); n++; end
    tests++;
    if (n !== 18) begin $display("FAIL glitch_refilter: got %0d want 18", n); fails++; end
    repeat (4) tick();
    tests++;
    if ({out_rst_n, locked} !== 3'b11_1) begin
      $display("FAIL glitch_run: got out=%b lck=%b want 11 1", out_rst_n, locked);
      fails++;
    end
    $display("[TB] test_glitch done");
  endtask

  task automatic test_timeout();
    pll_lock = 1'b0;
    bring_to_wait();
    n = 0;
    while (retry_cnt !== 2'd1 && n < 1200) begin tick(); n++; end
    tests++;
    if (n !== 1000 || pll_rst !== 1'b1) begin
      $display("FAIL timeout1: got cycles=%0d rst=%b want 1000 1", n, pll_rst);
      fails++;
    end
    n = 0;
    while (retry_cnt !== 2'd2 && n < 1200) begin tick(); n++; end
    tests++;
    if (n !== 1008) begin $display("FAIL timeout2: got %0d want 1008", n); fails++; end
    n = 0;
    while (fail !== 1'b1 && n < 1200) begin tick(); n++; end
    tests++;
    if (n !== 1008) begin $display("FAIL timeout3: got %0d want 1008", n); fails++; end
    tests++;
    if ({pll_pwd, pll_rst, retry_cnt, out_rst_n, locked} !== 7'b1_1_11_00_0) begin
      $display("FAIL fail_state: got pwd=%b rst=%b retry=%0d out=%b lck=%b want 1 1 3 00 0",
               pll_pwd, pll_rst, retry_cnt, out_rst_n, locked);
      fails++;
    end
    pll_lock = 1'b1;
    repeat (30) tick();
    tests++;
    if ({fail, locked} !== 2'b10) begin
      $display("FAIL fail_sticky: got fail=%b lck=%b want 1 0", fail, locked);
      fails++;
    end
    $display("[TB] test_timeout done");
  endtask

  // Entered from FAIL with pll_lock already high.
  task automatic test_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests++;
    if ({pll_pwd, pll_rst, fail, retry_cnt, out_rst_n} !== 7'b1_1_0_00_00) begin
      $display("FAIL restart_fail: got pwd=%b rst=%b fail=%b retry=%0d out=%b want 1 1 0 0 00",
               pll_pwd, pll_rst, fail, retry_cnt, out_rst_n);
      fails++;
    end
    n = 0;
    while (pll_pwd !== 1'b0 && n < 50) begin tick(); n++; end
    tests++;
    if (n !== 4) begin $display("FAIL restart_pwd: got %0d want 4", n); fails++; end
    n = 0;
    while (out_rst_n[0] !== 1'b1 && n < 100) begin tick(); n++; end
    tests++;
    if (n !== 24) begin $display("FAIL restart_relock: got %0d want 24", n); fails++; end
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests++;
    if ({pll_pwd, pll_rst, out_rst_n, locked, retry_cnt} !== 7'b1_1_00_0_00) begin
      $display("FAIL restart_release: got pwd=%b rst=%b out=%b lck=%b retry=%0d want 1 1 00 0 0",
               pll_pwd, pll_rst, out_rst_n, locked, retry_cnt);
      fails++;
    end
    $display("[TB] test_restart done");
  endtask

  task automatic test_loss();
    pll_lock = 1'b1;
    bring_to_wait();
    n = 0;
    while (locked !== 1'b1 && n < 100) begin tick(); n++; end
    tests++;
    if (n !== 20) begin $display("FAIL loss_prep: got %0d want 20", n); fails++; end
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 1;
    while (out_rst_n !== 2'b00 && n < 20) begin tick(); n++; end
    tests++;
    if (n !== 3) begin $display("FAIL loss_latency: got %0d want 3", n); fails++; end
    tests++;
    if ({pll_rst, pll_pwd, locked, retry_cnt} !== 5'b1_0_0_00) begin
      $display("FAIL loss_state: got rst=%b pwd=%b lck=%b retry=%0d want 1 0 0 0",
               pll_rst, pll_pwd, locked, retry_cnt);
      fails++;
    end
    n = 0;
    while (pll_rst !== 1'b0 && n < 50) begin tick(); n++; end
    tests++;
    if (n !== 8) begin $display("FAIL loss_rst_width: got %0d want 8", n); fails++; end
    n = 0;
    while (locked !== 1'b1 && n < 100) begin tick(); n++; end
    tests++;
    if (n !== 20 || out_rst_n !== 2'b11) begin
      $display("FAIL loss_relock: got cycles=%0d out=%b want 20 11", n, out_rst_n);
      fails++;
    end
`ifdef PLL_LOSS_CNT_EN
    tests++;
    if (loss_cnt !== 8'd1) begin $display("FAIL loss_cnt: got %0d want 1", loss_cnt); fails++; end
`endif
    // Mid-operation reset overrides everything on the next edge.
    rst_n = 1'b0;
    tick();
    tests++;
    if ({pll_pwd, pll_rst, out_rst_n, locked} !== 5'b1_1_00_0) begin
      $display("FAIL midrun_reset: got pwd=%b rst=%b out=%b lck=%b want 1 1 00 0",
               pll_pwd, pll_rst, out_rst_n, locked);
      fails++;
    end
`ifdef PLL_LOSS_CNT_EN
    tests++;
    if (loss_cnt !== 8'd0) begin $display("FAIL loss_cnt_clear: got %0d want 0", loss_cnt); fails++; end
`endif
    rst_n = 1'b1;
    $display("[TB] test_loss done");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_timeout();
    test_restart();
    test_loss();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
